// File: rtl/bht_ctrl.sv
// Branch history table controller: power-up/flush init sweep plus an ordered update queue.
// Optional macro BHT_CTRL_DROP_STATS_EN enables the saturating dropped-update counter.
module bht_ctrl #(
  parameter int unsigned SET_COUNT   = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   stall_fetch_i,
  input  logic                   upd_valid_i,
  input  logic [INDEX_WIDTH-1:0] upd_index_i,
  input  logic                   upd_taken_i,
  input  logic                   flush_i,
  output logic                   bht_update_o,
  output logic                   branch_taken_o,
  output logic [INDEX_WIDTH-1:0] set_index_exec_o,
  output logic                   bht_init_o,
  output logic                   busy_o,
  output logic                   fifo_full_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [INDEX_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  // Full is judged at the start of the cycle, so a same-cycle pop never frees a slot.
  assign push  = (state_q == StRun) & upd_valid_i & ~full & ~flush_i;
  assign pop   = bht_update_o & ~flush_i;

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      state_d  = StInit;
      sweep_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (state_q == StInit) begin
        sweep_d = sweep_q + INDEX_WIDTH'(1);
        if (sweep_q == INDEX_WIDTH'(SET_COUNT - 1)) begin
          state_d = StRun;
          sweep_d = '0;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    busy_o           = (state_q == StInit);
    bht_init_o       = (state_q == StInit);
    bht_update_o     = (state_q == StRun) & ~empty & ~stall_fetch_i;
    set_index_exec_o = '0;
    branch_taken_o   = 1'b0;
    fifo_full_o      = full;
    if (state_q == StInit) begin
      set_index_exec_o = sweep_q;
    end else if (bht_update_o) begin
      {set_index_exec_o, branch_taken_o} = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= StInit;
      sweep_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {upd_index_i, upd_taken_i};
  end

`ifdef BHT_CTRL_DROP_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = upd_valid_i & (flush_i | (state_q == StInit) | full);

  // Survives flush; only the async reset clears it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 SHALL have parameter SET_COUNT, default 32, number of BHT entries.
REQ-002 SHALL have parameter INDEX_WIDTH, default 5, BHT index width; SET_COUNT = 2**INDEX_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, update-queue entries, power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_i  in  1  clock; arst_i  in  1  async reset, active-high.
REQ-005 SHALL have port stall_fetch_i  in  1  fetch stall; the BHT must not be updated while it is high.
REQ-006 SHALL have port upd_valid_i  in  1  resolved branch update request from execute.
REQ-007 SHALL have port upd_index_i  in  INDEX_WIDTH  BHT index of the resolved branch.
REQ-008 SHALL have port upd_taken_i  in  1  resolved direction (1 = taken).
REQ-009 SHALL have port flush_i  in  1  request to reinitialise the whole table.
REQ-010 SHALL have port bht_update_o  out  1  BHT counter-update strobe.
REQ-011 SHALL have port branch_taken_o  out  1  direction for the update.
REQ-012 SHALL have port set_index_exec_o  out  INDEX_WIDTH  index for the update or init write.
REQ-013 SHALL have port bht_init_o  out  1  forces entry set_index_exec_o to 2'b01 (weakly not taken).
REQ-014 SHALL have port busy_o  out  1  high while in INIT.
REQ-015 SHALL have port fifo_full_o  out  1  queue holds FIFO_DEPTH entries.
REQ-016 SHALL have port drop_cnt_o  out  16  dropped-update count (see Configuration).

Function
REQ-017 SHALL implement FSM states INIT and RUN.
REQ-018 INIT SHALL write one entry per cycle, indices 0..SET_COUNT-1 ascending: bht_init_o=1, set_index_exec_o=sweep index, bht_update_o=0, irrespective of stall_fetch_i.
REQ-019 After the write to index SET_COUNT-1, the FSM SHALL go to RUN on the next edge; a sweep SHALL take exactly SET_COUNT cycles.
REQ-020 flush_i=1 in any state SHALL clear the queue and (re)enter INIT with the sweep index at 0 on the next edge; flush_i has priority over every other event.
REQ-021 In RUN, when upd_valid_i=1 and the queue is not full at the start of the cycle, {index, taken} SHALL be pushed; there is no same-cycle bypass.
REQ-022 An update SHALL be dropped when the queue is full, or when in INIT, or when flush_i=1, even if a pop occurs in the same cycle.
REQ-023 bht_update_o SHALL equal RUN & queue-not-empty & ~stall_fetch_i, with branch_taken_o and set_index_exec_o taken from the queue head; the head SHALL pop on that edge.
REQ-024 Push and pop in the same cycle SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Updates SHALL be issued in arrival order, one per unstalled cycle; latency from push to bht_update_o SHALL be at least 1 cycle.
REQ-026 When idle, branch_taken_o and set_index_exec_o SHALL be 0; bht_init_o and bht_update_o SHALL never both be 1.

Reset
REQ-027 On arst_i the FSM SHALL enter INIT with the sweep index at 0 and the queue empty, so that every entry, including SET_COUNT-1, is initialised after reset.
REQ-028 Reset output values SHALL be: busy_o=1, bht_init_o=1, set_index_exec_o=0, bht_update_o=0, branch_taken_o=0, fifo_full_o=0, drop_cnt_o=0.
REQ-029 Reset asserted mid-sweep or mid-drain SHALL discard all state immediately.

Configuration
REQ-030 With macro BHT_CTRL_DROP_STATS_EN defined, drop_cnt_o SHALL increment by 1 per dropped update (REQ-022), saturate at 16'hFFFF, and SHALL NOT be cleared by flush_i.
REQ-031 Without BHT_CTRL_DROP_STATS_EN, drop_cnt_o SHALL be tied to 0 and no counter SHALL be synthesised.

Verification
REQ-032 Release reset, no requests -> bht_init_o high for 32 cycles with indices 0..31, busy_o falls on cycle 33, and all outputs are then 0.
REQ-033 In RUN, push (3,T), (7,N), (3,T) on consecutive cycles with stall_fetch_i=0 -> bht_update_o pulses with index/taken 3/1, 7/0, 3/1 in that order, starting one cycle after the first push.
REQ-034 stall_fetch_i=1, 5 consecutive valid updates -> 4 queued, fifo_full_o=1, drop_cnt_o=1 (macro on) or 0 (macro off); release stall -> 4 updates drain in 4 cycles.
REQ-035 Full queue with push, and stall released in the same cycle -> one pop, push dropped, occupancy 3.
REQ-036 flush_i at sweep index 10 with 2 entries queued -> sweep restarts at 0, queue empty, no bht_update_o until 32 cycles later.
REQ-037 arst_i pulse while draining 3 entries -> no further bht_update_o, new sweep starts at index 0.
